// File: rtl/fr_mac_pkg.sv
// Shared types and widths for the floating MAC fraction datapath.
package fr_mac_pkg;
    localparam int FRAC_W = 24;
    localparam int SUM_W  = 25;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             sign;
    } rsp_t;
endpackage

// File: rtl/fr_rsp_fifo.sv
// Per-requester response FIFO. Push and pop may coincide at any fill level;
// an empty FIFO never bypasses, so a pushed entry is visible the next cycle.
module fr_rsp_fifo
    import fr_mac_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  rsp_t          push_data,
    input  logic          pop,
    output rsp_t          head,
    output logic [CW-1:0] count
);
    rsp_t          mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Credits make an unfreed push into a full FIFO unreachable.
    assert property (@(posedge clock) disable iff (!resetn)
        !(push && !pop && count == CW'(DEPTH)));
    assert property (@(posedge clock) disable iff (!resetn)
        !(pop && count == '0));
endmodule

// File: rtl/fr_adder_arbiter.sv
// Round-robin, credit-gated sharing of one fixed-latency fraction adder among
// NUM_REQ requesters; a tag pipe routes each result back to its requester's FIFO.
module fr_adder_arbiter
    import fr_mac_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDER_LAT  = 3,
    parameter int RESP_DEPTH = 2
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FRAC_W-1:0] req_a,
    input  logic [NUM_REQ*FRAC_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sign,
    output logic [FRAC_W-1:0]         add_in1,
    output logic [FRAC_W-1:0]         add_in2,
    output logic                      add_sign_in,
    input  logic [SUM_W-1:0]          add_out_sum,
    input  logic                      add_out_sign,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [NUM_REQ*SUM_W-1:0]  rsp_sum,
    output logic [NUM_REQ-1:0]        rsp_sign,
    output logic                      busy
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = $clog2(RESP_DEPTH + 1);

    // Handshakes on both sides transfer exactly on a cycle where valid && ready
    // is sampled high; valid never waits on ready, and ready here never waits on
    // anything but valid, credit and the round-robin pointer.
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       winner;
    logic                 grant;
    logic [NUM_REQ-1:0]   eligible;
    logic [CW-1:0]        credit     [NUM_REQ];
    logic [CW-1:0]        fifo_count [NUM_REQ];
    rsp_t                 fifo_head  [NUM_REQ];
    logic [ADDER_LAT-1:0] tag_v;
    logic [IDW-1:0]       tag_id     [ADDER_LAT];
    logic [NUM_REQ-1:0]   push_vec;
    logic [NUM_REQ-1:0]   pop_vec;

    always_comb begin
        grant     = 1'b0;
        winner    = '0;
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!grant && eligible[j]) begin
                grant  = 1'b1;
                winner = IDW'(j);
            end
        end
        if (grant) req_ready[winner] = 1'b1;
        add_in1     = grant ? req_a[FRAC_W*int'(winner) +: FRAC_W] : '0;
        add_in2     = grant ? req_b[FRAC_W*int'(winner) +: FRAC_W] : '0;
        add_sign_in = grant ? req_sign[winner] : 1'b0;
    end

    // Tag stage ADDER_LAT-1 lines up with the adder's output for the same op.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
            tag_v  <= '0;
            for (int s = 0; s < ADDER_LAT; s++) tag_id[s] <= '0;
        end else begin
            if (grant) rr_ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            tag_v[0]  <= grant;
            tag_id[0] <= winner;
            for (int s = 1; s < ADDER_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign eligible[i]  = req_valid[i] && (credit[i] != '0);
        assign push_vec[i]  = tag_v[ADDER_LAT-1] && (tag_id[ADDER_LAT-1] == IDW'(i));
        assign pop_vec[i]   = rsp_valid[i] && rsp_ready[i];
        assign rsp_valid[i] = (fifo_count[i] != '0);
        assign rsp_sum[SUM_W*i +: SUM_W] = fifo_head[i].sum;
        assign rsp_sign[i]  = fifo_head[i].sign;

        // Credit counts FIFO slots not yet claimed by a queued or in-flight result.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                credit[i] <= CW'(RESP_DEPTH);
            end else begin
                case ({req_ready[i], pop_vec[i]})
                    2'b10:   credit[i] <= credit[i] - 1'b1;
                    2'b01:   credit[i] <= credit[i] + 1'b1;
                    default: credit[i] <= credit[i];
                endcase
            end
        end

        fr_rsp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
            .clock     (clock),
            .resetn    (resetn),
            .push      (push_vec[i]),
            .push_data (rsp_t'({add_out_sum, add_out_sign})),
            .pop       (pop_vec[i]),
            .head      (fifo_head[i]),
            .count     (fifo_count[i])
        );
    end

    assign busy = (|tag_v) || (|rsp_valid);
endmodule

// File: tb/tb_fr_adder_arbiter.sv
// Directed bench for fr_adder_arbiter with a queue-based reference model and a
// behavioural fixed-latency adder standing in for the real one.
module tb_fr_adder_arbiter;
    localparam int NUM_REQ = 2;
    localparam int LAT     = 3;
    localparam int DEPTH   = 2;
    localparam int EW      = 58;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_sign;
    logic [NUM_REQ*24-1:0] req_a, req_b;
    logic [23:0]           add_in1, add_in2;
    logic                  add_sign_in;
    logic [24:0]           add_out_sum;
    logic                  add_out_sign;
    logic [NUM_REQ-1:0]    rsp_valid, rsp_ready, rsp_sign;
    logic [NUM_REQ*25-1:0] rsp_sum;
    logic                  busy;

    fr_adder_arbiter #(.NUM_REQ(NUM_REQ), .ADDER_LAT(LAT), .RESP_DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .req_sign(req_sign), .add_in1(add_in1), .add_in2(add_in2), .add_sign_in(add_sign_in),
        .add_out_sum(add_out_sum), .add_out_sign(add_out_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_sign(rsp_sign),
        .busy(busy)
    );

    // clock / reset block
    always #5 clock = ~clock;
    int cyc = 0;
    always @(posedge clock) cyc++;

    // Fixed-latency adder standing outside the arbiter.
    logic [24:0] p_sum  [LAT];
    logic        p_sign [LAT];
    initial for (int s = 0; s < LAT; s++) begin p_sum[s] = '0; p_sign[s] = 1'b0; end
    always @(posedge clock) begin
        for (int s = LAT - 1; s > 0; s--) begin
            p_sum[s]  <= p_sum[s-1];
            p_sign[s] <= p_sign[s-1];
        end
        p_sum[0]  <= {1'b0, add_in1} + {1'b0, add_in2};
        p_sign[0] <= add_sign_in;
    end
    assign add_out_sum  = p_sum[LAT-1];
    assign add_out_sign = p_sign[LAT-1];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // scoreboard: per-requester expected queue of {ready_cycle, sign, sum}
    logic [EW-1:0] exp_q [NUM_REQ][$];
    int            m_credit [NUM_REQ];
    int            m_rr;

    always @(negedge clock) begin : compare
        int                 w;
        logic [NUM_REQ-1:0] exp_ready, exp_v;
        logic [23:0]        ea, eb;
        logic               es, any;
        logic [EW-1:0]      h;
        logic [24:0]        s;
        if (!resetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_q[i].delete();
                m_credit[i] = DEPTH;
            end
            m_rr = 0;
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_add_in", 64'({add_in1, add_in2, add_sign_in}), 64'd0);
        end else begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_rr + k) % NUM_REQ;
                if (w < 0 && req_valid[j] && m_credit[j] > 0) w = j;
            end
            exp_ready = '0; ea = '0; eb = '0; es = 1'b0;
            if (w >= 0) begin
                exp_ready[w] = 1'b1;
                ea = req_a[24*w +: 24];
                eb = req_b[24*w +: 24];
                es = req_sign[w];
            end
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("add_in", 64'({add_in1, add_in2, add_sign_in}), 64'({ea, eb, es}));
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                exp_v[i] = 1'b0;
                if (exp_q[i].size() > 0) begin
                    any = 1'b1;
                    h = exp_q[i][0];
                    exp_v[i] = (int'(h[57:26]) <= cyc);
                end
            end
            check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_v[i]) begin
                    h = exp_q[i][0];
                    check("rsp_head", 64'({rsp_sign[i], rsp_sum[25*i +: 25]}), 64'(h[25:0]));
                end
            end
            check("busy", 64'(busy), 64'(any));
            if (w >= 0) begin
                s = {1'b0, ea} + {1'b0, eb};
                exp_q[w].push_back({32'(cyc + LAT + 1), es, s});
                m_credit[w]--;
                m_rr = (w + 1) % NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (exp_v[i] && rsp_ready[i]) begin
                    void'(exp_q[i].pop_front());
                    m_credit[i]++;
                end
            end
        end
    end

    // driver tasks
    function automatic logic [23:0] gen_a(int i, int k);
        return 24'(k * 24'h02F1B3 + i * 24'h5A5A5A + 24'h7FF000);
    endfunction
    function automatic logic [23:0] gen_b(int i, int k);
        return 24'(k * 24'h0C0FFE + i * 24'h123457 + 24'h800001);
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (busy && t < 100) begin next_cycle(); t++; end
        @(negedge clock);
        check({name, "_busy"}, 64'(busy), 64'd0);
        for (int i = 0; i < NUM_REQ; i++) check({name, "_no_loss"}, 64'(exp_q[i].size()), 64'd0);
    endtask

    // One isolated op on requester i; result pinned to a literal at issue+LAT+1.
    task automatic single_op(input int i, input logic [23:0] a, input logic [23:0] b,
                             input logic s, input logic [24:0] want_sum, input string name);
        rsp_ready = '0;
        next_cycle();
        req_a[24*i +: 24] = a;
        req_b[24*i +: 24] = b;
        req_sign[i]       = s;
        req_valid[i]      = 1'b1;
        @(negedge clock);
        check({name, "_grant"}, 64'(req_ready), 64'(1 << i));
        next_cycle();
        req_valid = '0;
        repeat (LAT - 1) @(posedge clock);
        @(negedge clock);
        check({name, "_not_early"}, 64'(rsp_valid[i]), 64'd0);
        @(negedge clock);
        check({name, "_valid"}, 64'(rsp_valid[i]), 64'd1);
        check({name, "_sum"}, 64'(rsp_sum[25*i +: 25]), 64'(want_sum));
        check({name, "_sign"}, 64'(rsp_sign[i]), 64'(s));
        next_cycle();
        rsp_ready = '1;
        @(negedge clock);
        check({name, "_idle_add_in"}, 64'({add_in1, add_in2}), 64'd0);
    endtask

    initial begin : main
        int                 cnt [NUM_REQ];
        int                 last, w, g0, g1, t;
        logic [NUM_REQ-1:0] fired;
        resetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sign = '0; rsp_ready = '0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        @(negedge clock);
        check("post_reset_ready", 64'(req_ready), 64'd0);

        single_op(0, 24'h800000, 24'h800000, 1'b1, 25'h1000000, "t1");
        single_op(1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 25'h1FFFFFE, "t6");

        // Both requesters stream; credit bubbles allowed but grant order alternates.
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] = 0;
            req_a[24*i +: 24] = gen_a(i, 0);
            req_b[24*i +: 24] = gen_b(i, 0);
            req_sign[i] = 1'(i);
        end
        next_cycle();
        req_valid = '1;
        last = -1;
        t = 0;
        while ((cnt[0] < 100 || cnt[1] < 100) && t < 2000) begin
            @(negedge clock);
            fired = req_valid & req_ready;
            if (fired != '0) begin
                w = fired[1] ? 1 : 0;
                if (last >= 0) check("rr_alternate", 64'(w), 64'(1 - last));
                last = w;
            end
            next_cycle();
            t++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fired[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 100) req_valid[i] = 1'b0;
                    req_a[24*i +: 24] = gen_a(i, cnt[i]);
                    req_b[24*i +: 24] = gen_b(i, cnt[i]);
                    req_sign[i] = 1'(cnt[i] + i);
                end
            end
        end
        check("t2_ops0", 64'(cnt[0]), 64'd100);
        check("t2_ops1", 64'(cnt[1]), 64'd100);
        drain("t2");

        // Requester 0 never pops: exactly DEPTH grants, requester 1 keeps going.
        next_cycle();
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        g0 = 0; g1 = 0;
        repeat (20) begin
            @(negedge clock);
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
        end
        check("t3_grants0", 64'(g0), 64'(DEPTH));
        check("t3_req1_served", 64'(g1 >= 4), 64'd1);
        check("t3_blocked", 64'(req_ready[0]), 64'd0);
        next_cycle();
        rsp_ready = 2'b11;
        @(negedge clock);
        check("t3_pop_cycle", 64'({rsp_valid[0], req_ready[0]}), 64'b10);
        @(negedge clock);
        check("t3_regrant", 64'(req_ready[0]), 64'd1);
        next_cycle();
        req_valid = '0;
        drain("t3");

        // Pop and grant on requester 0 in the same cycle while credit is 1.
        rsp_ready = 2'b10;
        next_cycle();
        req_valid = 2'b01;
        next_cycle();
        req_valid = '0;
        t = 0;
        do begin @(negedge clock); t++; end while (!rsp_valid[0] && t < 20);
        check("t4_wait_rsp", 64'(rsp_valid[0]), 64'd1);
        next_cycle();
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        @(negedge clock);
        check("t4_pop_and_grant", 64'({rsp_valid[0], req_ready[0]}), 64'b11);
        next_cycle();
        rsp_ready = 2'b10;
        @(negedge clock);
        check("t4_credit_kept", 64'(req_ready[0]), 64'd1);
        next_cycle();
        @(negedge clock);
        check("t4_credit_spent", 64'(req_ready[0]), 64'd0);
        next_cycle();
        req_valid = '0;
        rsp_ready = 2'b11;
        drain("t4");

        // Three ops in flight (last grant to 0, so rr would point at 1), then reset.
        next_cycle();
        req_valid = 2'b11;
        next_cycle();
        next_cycle();
        req_valid = 2'b01;
        next_cycle();
        resetn = 1'b0;
        req_valid = '0;
        @(negedge clock);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        next_cycle();
        resetn = 1'b1;
        req_valid = 2'b11;
        @(negedge clock);
        check("t5_rr_ptr_zero", 64'(req_ready), 64'b01);
        g0 = 1;
        next_cycle();
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        repeat (8) begin
            @(negedge clock);
            if (req_ready[0]) g0++;
        end
        check("t5_credits_full", 64'(g0), 64'(DEPTH));
        next_cycle();
        req_valid = '0;
        rsp_ready = 2'b11;
        drain("t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
